// File: rtl/ysyx_22050019_axi_arb.sv
// ysyx_22050019_axi_arb
//
// Shares one AXI-lite slave port between the instruction-fetch unit (read-only
// master) and the load/store unit (read/write master). Exactly one whole
// transaction is owned at a time. Owners are chosen round-robin when both
// masters contend, and handshakes are forwarded combinationally while owned.
//
// Ports
//   clk, rst_n            clock, asynchronous active-low reset
//   if_ar* / if_r*        IFU read address / read response channels
//   ls_ar* / ls_r*        LSU read address / read response channels
//   ls_aw* / ls_w* / ls_b* LSU write address / data / response channels
//   m_*                   shared slave-side AXI-lite channels
//   grant_o               current owner: 00 none, 01 IFU rd, 10 LSU rd, 11 LSU wr
module ysyx_22050019_axi_arb #(
    parameter int unsigned ADDR_W = 64,
    parameter int unsigned DATA_W = 64
) (
    input  logic                  clk,
    input  logic                  rst_n,
    // IFU read master
    input  logic                  if_arvalid_i,
    input  logic [ADDR_W-1:0]     if_araddr_i,
    output logic                  if_arready_o,
    output logic                  if_rvalid_o,
    output logic [DATA_W-1:0]     if_rdata_o,
    output logic [1:0]            if_rresp_o,
    input  logic                  if_rready_i,
    // LSU read/write master
    input  logic                  ls_arvalid_i,
    input  logic [ADDR_W-1:0]     ls_araddr_i,
    output logic                  ls_arready_o,
    output logic                  ls_rvalid_o,
    output logic [DATA_W-1:0]     ls_rdata_o,
    output logic [1:0]            ls_rresp_o,
    input  logic                  ls_rready_i,
    input  logic                  ls_awvalid_i,
    input  logic [ADDR_W-1:0]     ls_awaddr_i,
    output logic                  ls_awready_o,
    input  logic                  ls_wvalid_i,
    input  logic [DATA_W-1:0]     ls_wdata_i,
    input  logic [DATA_W/8-1:0]   ls_wstrb_i,
    output logic                  ls_wready_o,
    output logic                  ls_bvalid_o,
    output logic [1:0]            ls_bresp_o,
    input  logic                  ls_bready_i,
    // Shared slave port
    output logic                  m_arvalid_o,
    output logic [ADDR_W-1:0]     m_araddr_o,
    input  logic                  m_arready_i,
    input  logic                  m_rvalid_i,
    input  logic [DATA_W-1:0]     m_rdata_i,
    input  logic [1:0]            m_rresp_i,
    output logic                  m_rready_o,
    output logic                  m_awvalid_o,
    output logic [ADDR_W-1:0]     m_awaddr_o,
    input  logic                  m_awready_i,
    output logic                  m_wvalid_o,
    output logic [DATA_W-1:0]     m_wdata_o,
    output logic [DATA_W/8-1:0]   m_wstrb_o,
    input  logic                  m_wready_i,
    input  logic                  m_bvalid_i,
    input  logic [1:0]            m_bresp_i,
    output logic                  m_bready_o,
    // Owner indication
    output logic [1:0]            grant_o
);

    // State encoding doubles as the grant value.
    localparam logic [1:0] StIdle = 2'b00;
    localparam logic [1:0] StIfRd = 2'b01;
    localparam logic [1:0] StLsRd = 2'b10;
    localparam logic [1:0] StLsWr = 2'b11;

    logic [1:0] state_q, state_d;
    logic       last_owner_q, last_owner_d;  // 0 = IFU, 1 = LSU
    logic       ar_done_q, ar_done_d;
    logic       aw_done_q, aw_done_d;
    logic       w_done_q, w_done_d;

    logic if_req, ls_rd_req, ls_wr_req, ls_req;
    logic ar_hs, r_hs, aw_hs, w_hs, b_hs;

    assign if_req    = if_arvalid_i;
    assign ls_rd_req = ls_arvalid_i;
    assign ls_wr_req = ls_awvalid_i | ls_wvalid_i;
    assign ls_req    = ls_rd_req | ls_wr_req;

    assign ar_hs = m_arvalid_o & m_arready_i;
    assign r_hs  = m_rvalid_i & m_rready_o;
    assign aw_hs = m_awvalid_o & m_awready_i;
    assign w_hs  = m_wvalid_o & m_wready_i;
    assign b_hs  = m_bvalid_i & m_bready_o;

    assign grant_o = state_q;

    // Next-state: arbitration in idle, completion tracking while owned.
    always_comb begin
        state_d      = state_q;
        last_owner_d = last_owner_q;
        ar_done_d    = ar_done_q;
        aw_done_d    = aw_done_q;
        w_done_d     = w_done_q;
        unique case (state_q)
            StIdle: begin
                // IFU wins if it is alone or if the LSU owned the port last.
                if (if_req && (!ls_req || last_owner_q)) begin
                    state_d      = StIfRd;
                    last_owner_d = 1'b0;
                end else if (ls_req) begin
                    state_d      = ls_wr_req ? StLsWr : StLsRd;
                    last_owner_d = 1'b1;
                end
            end
            StIfRd, StLsRd: begin
                if (ar_hs) begin
                    ar_done_d = 1'b1;
                end
                if (r_hs) begin
                    state_d   = StIdle;
                    ar_done_d = 1'b0;
                end
            end
            StLsWr: begin
                if (aw_hs) begin
                    aw_done_d = 1'b1;
                end
                if (w_hs) begin
                    w_done_d = 1'b1;
                end
                if (b_hs) begin
                    state_d   = StIdle;
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Channel routing: everything is zero unless the owner's path is selected.
    always_comb begin
        if_arready_o = 1'b0;
        if_rvalid_o  = 1'b0;
        if_rdata_o   = '0;
        if_rresp_o   = 2'b00;
        ls_arready_o = 1'b0;
        ls_rvalid_o  = 1'b0;
        ls_rdata_o   = '0;
        ls_rresp_o   = 2'b00;
        ls_awready_o = 1'b0;
        ls_wready_o  = 1'b0;
        ls_bvalid_o  = 1'b0;
        ls_bresp_o   = 2'b00;
        m_arvalid_o  = 1'b0;
        m_araddr_o   = '0;
        m_rready_o   = 1'b0;
        m_awvalid_o  = 1'b0;
        m_awaddr_o   = '0;
        m_wvalid_o   = 1'b0;
        m_wdata_o    = '0;
        m_wstrb_o    = '0;
        m_bready_o   = 1'b0;
        unique case (state_q)
            StIfRd: begin
                // Done flag blocks a second address beat if the master holds valid.
                m_arvalid_o  = if_arvalid_i & ~ar_done_q;
                m_araddr_o   = if_araddr_i;
                if_arready_o = m_arready_i & ~ar_done_q;
                if_rvalid_o  = m_rvalid_i;
                if_rdata_o   = m_rdata_i;
                if_rresp_o   = m_rresp_i;
                m_rready_o   = if_rready_i;
            end
            StLsRd: begin
                m_arvalid_o  = ls_arvalid_i & ~ar_done_q;
                m_araddr_o   = ls_araddr_i;
                ls_arready_o = m_arready_i & ~ar_done_q;
                ls_rvalid_o  = m_rvalid_i;
                ls_rdata_o   = m_rdata_i;
                ls_rresp_o   = m_rresp_i;
                m_rready_o   = ls_rready_i;
            end
            StLsWr: begin
                m_awvalid_o  = ls_awvalid_i & ~aw_done_q;
                m_awaddr_o   = ls_awaddr_i;
                ls_awready_o = m_awready_i & ~aw_done_q;
                m_wvalid_o   = ls_wvalid_i & ~w_done_q;
                m_wdata_o    = ls_wdata_i;
                m_wstrb_o    = ls_wstrb_i;
                ls_wready_o  = m_wready_i & ~w_done_q;
                ls_bvalid_o  = m_bvalid_i;
                ls_bresp_o   = m_bresp_i;
                m_bready_o   = ls_bready_i;
            end
            default: begin
            end
        endcase
    end

    // last_owner resets to LSU so the IFU wins the first contended grant.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            last_owner_q <= 1'b1;
            ar_done_q    <= 1'b0;
            aw_done_q    <= 1'b0;
            w_done_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_owner_q <= last_owner_d;
            ar_done_q    <= ar_done_d;
            aw_done_q    <= aw_done_d;
            w_done_q     <= w_done_d;
        end
    end

endmodule

// File: tb/tb_ysyx_22050019_axi_arb.sv
// Testbench for ysyx_22050019_axi_arb: directed master transactions against a
// small slave model, with an owner-level reference model compared every cycle.
module tb_ysyx_22050019_axi_arb;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    logic        if_arvalid = 0, if_rready = 1;
    logic [63:0] if_araddr = 0;
    logic        if_arready, if_rvalid;
    logic [63:0] if_rdata;
    logic [1:0]  if_rresp;
    logic        ls_arvalid = 0, ls_rready = 1, ls_awvalid = 0, ls_wvalid = 0, ls_bready = 0;
    logic [63:0] ls_araddr = 0, ls_awaddr = 0, ls_wdata = 0;
    logic [7:0]  ls_wstrb = 0;
    logic        ls_arready, ls_rvalid, ls_awready, ls_wready, ls_bvalid;
    logic [63:0] ls_rdata;
    logic [1:0]  ls_rresp, ls_bresp;
    logic        m_arvalid, m_rready, m_awvalid, m_wvalid, m_bready;
    logic [63:0] m_araddr, m_awaddr, m_wdata;
    logic [7:0]  m_wstrb;
    logic        m_arready = 0, m_rvalid = 0, m_awready = 0, m_wready = 0, m_bvalid = 0;
    logic [63:0] m_rdata = 0;
    logic [1:0]  m_rresp = 0, m_bresp = 0;
    logic [1:0]  grant;

    ysyx_22050019_axi_arb #(.ADDR_W(64), .DATA_W(64)) dut (
        .clk(clk), .rst_n(rst_n),
        .if_arvalid_i(if_arvalid), .if_araddr_i(if_araddr), .if_arready_o(if_arready),
        .if_rvalid_o(if_rvalid), .if_rdata_o(if_rdata), .if_rresp_o(if_rresp),
        .if_rready_i(if_rready),
        .ls_arvalid_i(ls_arvalid), .ls_araddr_i(ls_araddr), .ls_arready_o(ls_arready),
        .ls_rvalid_o(ls_rvalid), .ls_rdata_o(ls_rdata), .ls_rresp_o(ls_rresp),
        .ls_rready_i(ls_rready),
        .ls_awvalid_i(ls_awvalid), .ls_awaddr_i(ls_awaddr), .ls_awready_o(ls_awready),
        .ls_wvalid_i(ls_wvalid), .ls_wdata_i(ls_wdata), .ls_wstrb_i(ls_wstrb),
        .ls_wready_o(ls_wready), .ls_bvalid_o(ls_bvalid), .ls_bresp_o(ls_bresp),
        .ls_bready_i(ls_bready),
        .m_arvalid_o(m_arvalid), .m_araddr_o(m_araddr), .m_arready_i(m_arready),
        .m_rvalid_i(m_rvalid), .m_rdata_i(m_rdata), .m_rresp_i(m_rresp),
        .m_rready_o(m_rready),
        .m_awvalid_o(m_awvalid), .m_awaddr_o(m_awaddr), .m_awready_i(m_awready),
        .m_wvalid_o(m_wvalid), .m_wdata_o(m_wdata), .m_wstrb_o(m_wstrb),
        .m_wready_i(m_wready), .m_bvalid_i(m_bvalid), .m_bresp_i(m_bresp),
        .m_bready_o(m_bready),
        .grant_o(grant)
    );

    int n_checks = 0;
    int n_fail = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- reference model: who owns the port, what was accepted
    int own = 0;        // 0 none, 1 IFU read, 2 LSU read, 3 LSU write
    bit last_lsu = 1;   // most recent owner was the LSU
    bit addr_acc = 0, waddr_acc = 0, wdat_acc = 0;

    logic        e_if_arready, e_if_rvalid, e_ls_arready, e_ls_rvalid;
    logic        e_ls_awready, e_ls_wready, e_ls_bvalid;
    logic        e_m_arvalid, e_m_rready, e_m_awvalid, e_m_wvalid, e_m_bready;
    logic [1:0]  e_if_rresp, e_ls_rresp, e_ls_bresp;
    logic [63:0] e_if_rdata, e_ls_rdata, e_m_araddr, e_m_awaddr, e_m_wdata;
    logic [7:0]  e_m_wstrb;

    always_comb begin
        e_if_arready = 0; e_if_rvalid = 0; e_if_rdata = 0; e_if_rresp = 0;
        e_ls_arready = 0; e_ls_rvalid = 0; e_ls_rdata = 0; e_ls_rresp = 0;
        e_ls_awready = 0; e_ls_wready = 0; e_ls_bvalid = 0; e_ls_bresp = 0;
        e_m_arvalid = 0; e_m_araddr = 0; e_m_rready = 0; e_m_awvalid = 0; e_m_awaddr = 0;
        e_m_wvalid = 0; e_m_wdata = 0; e_m_wstrb = 0; e_m_bready = 0;
        if (own == 1) begin
            // the owner's read pair sees the slave; a second address beat is refused
            e_m_arvalid = if_arvalid && !addr_acc; e_m_araddr = if_araddr;
            e_if_arready = m_arready && !addr_acc;
            e_if_rvalid = m_rvalid; e_if_rdata = m_rdata; e_if_rresp = m_rresp;
            e_m_rready = if_rready;
        end else if (own == 2) begin
            e_m_arvalid = ls_arvalid && !addr_acc; e_m_araddr = ls_araddr;
            e_ls_arready = m_arready && !addr_acc;
            e_ls_rvalid = m_rvalid; e_ls_rdata = m_rdata; e_ls_rresp = m_rresp;
            e_m_rready = ls_rready;
        end else if (own == 3) begin
            e_m_awvalid = ls_awvalid && !waddr_acc; e_m_awaddr = ls_awaddr;
            e_ls_awready = m_awready && !waddr_acc;
            e_m_wvalid = ls_wvalid && !wdat_acc; e_m_wdata = ls_wdata; e_m_wstrb = ls_wstrb;
            e_ls_wready = m_wready && !wdat_acc;
            e_ls_bvalid = m_bvalid; e_ls_bresp = m_bresp; e_m_bready = ls_bready;
        end
    end

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            own <= 0; last_lsu <= 1; addr_acc <= 0; waddr_acc <= 0; wdat_acc <= 0;
        end else if (own == 0) begin
            if (if_arvalid && (!(ls_arvalid || ls_awvalid || ls_wvalid) || last_lsu)) begin
                own <= 1; last_lsu <= 0;
            end else if (ls_awvalid || ls_wvalid) begin
                own <= 3; last_lsu <= 1;
            end else if (ls_arvalid) begin
                own <= 2; last_lsu <= 1;
            end
        end else if (own == 3) begin
            if (e_m_awvalid && m_awready) waddr_acc <= 1;
            if (e_m_wvalid && m_wready) wdat_acc <= 1;
            if (m_bvalid && e_m_bready) begin own <= 0; waddr_acc <= 0; wdat_acc <= 0; end
        end else begin
            if (e_m_arvalid && m_arready) addr_acc <= 1;
            if (m_rvalid && e_m_rready) begin own <= 0; addr_acc <= 0; end
        end
    end

    // Compare process: every cycle, including reset
    always @(negedge clk) begin
        chk("ctrl",
            {grant, if_arready, if_rvalid, if_rresp, ls_arready, ls_rvalid, ls_rresp,
             ls_awready, ls_wready, ls_bvalid, ls_bresp, m_arvalid, m_rready, m_awvalid,
             m_wvalid, m_bready},
            {own[1:0], e_if_arready, e_if_rvalid, e_if_rresp, e_ls_arready, e_ls_rvalid,
             e_ls_rresp, e_ls_awready, e_ls_wready, e_ls_bvalid, e_ls_bresp, e_m_arvalid,
             e_m_rready, e_m_awvalid, e_m_wvalid, e_m_bready});
        chk("data", {if_rdata, ls_rdata, m_araddr, m_awaddr, m_wdata, m_wstrb},
            {e_if_rdata, e_ls_rdata, e_m_araddr, e_m_awaddr, e_m_wdata, e_m_wstrb});
    end

    // Grant log: value per cycle plus the sequence of granted owners
    logic [1:0] grant_at [4096];
    logic [1:0] prev_grant = 0;
    int gq[$];
    always @(negedge clk) begin
        grant_at[cyc % 4096] = grant;
        if (grant != 2'b00 && prev_grant == 2'b00) gq.push_back(int'(grant));
        prev_grant = grant;
    end

    // ---------------- slave model
    int          rd_lat = 2, rcnt = 0;
    logic [63:0] rdata_cfg = 0;
    logic [1:0]  rresp_cfg = 0, bresp_cfg = 0;
    bit          ar_ready_en = 1, aw_got = 0, w_got = 0;
    logic [63:0] s_araddr = 0, s_awaddr = 0, s_wdata = 0;
    logic [7:0]  s_wstrb = 0;
    int          s_aw_cyc = 0, s_w_cyc = 0;
    bit          ar_hs, r_hs, aw_hs, w_hs, b_hs;

    initial begin
        forever begin
            @(negedge clk);
            ar_hs = m_arvalid && m_arready; r_hs = m_rvalid && m_rready;
            aw_hs = m_awvalid && m_awready; w_hs = m_wvalid && m_wready;
            b_hs = m_bvalid && m_bready;
            if (ar_hs) s_araddr = m_araddr;
            if (aw_hs) begin s_awaddr = m_awaddr; s_aw_cyc = cyc; end
            if (w_hs) begin s_wdata = m_wdata; s_wstrb = m_wstrb; s_w_cyc = cyc; end
            @(posedge clk);
            #1;
            if (!rst_n) begin
                m_arready = 0; m_awready = 0; m_wready = 0; m_rvalid = 0; m_rdata = 0;
                m_rresp = 0; m_bvalid = 0; m_bresp = 0; rcnt = 0; aw_got = 0; w_got = 0;
            end else begin
                m_arready = ar_ready_en; m_awready = 1; m_wready = 1;
                if (r_hs) begin m_rvalid = 0; m_rdata = 0; m_rresp = 0; end
                if (ar_hs) rcnt = rd_lat;
                else if (rcnt > 0) begin
                    rcnt--;
                    if (rcnt == 0) begin m_rvalid = 1; m_rdata = rdata_cfg; m_rresp = rresp_cfg; end
                end
                if (aw_hs) aw_got = 1;
                if (w_hs) w_got = 1;
                if (b_hs) begin m_bvalid = 0; m_bresp = 0; aw_got = 0; w_got = 0; end
                else if (aw_got && w_got) begin m_bvalid = 1; m_bresp = bresp_cfg; end
            end
        end
    end

    // ---------------- master tasks (entered and left at posedge + 1)
    // IFU holds arvalid until its response, so a repeated address beat must be refused.
    task automatic if_read(input logic [63:0] a, output logic [63:0] d, output logic [1:0] r,
                           output int req_c, output int r_c);
        bit ok = 0;
        d = 0; r = 0; r_c = 0;
        if_arvalid = 1; if_araddr = a; req_c = cyc;
        for (int n = 0; n < 300 && !ok; n++) begin
            @(negedge clk);
            if (if_rvalid && if_rready) begin ok = 1; d = if_rdata; r = if_rresp; r_c = cyc; end
            @(posedge clk);
            #1;
        end
        if (!ok) chk("if_read_timeout", 0, 1);
        if_arvalid = 0; if_araddr = 0;
    endtask

    task automatic ls_read(input logic [63:0] a, output logic [63:0] d, output logic [1:0] r);
        bit ok = 0, arh;
        d = 0; r = 0;
        ls_arvalid = 1; ls_araddr = a;
        for (int n = 0; n < 300 && !ok; n++) begin
            @(negedge clk);
            if (ls_rvalid && ls_rready) begin ok = 1; d = ls_rdata; r = ls_rresp; end
            arh = ls_arvalid && ls_arready;
            @(posedge clk);
            #1;
            if (arh) ls_arvalid = 0;
        end
        if (!ok) chk("ls_read_timeout", 0, 1);
        ls_arvalid = 0;
    endtask

    // W is presented first; AW follows after 'lead' cycles. Both stay valid until
    // both are accepted. bready rises after bvalid has been seen 'bwait' cycles.
    task automatic ls_write(input logic [63:0] a, input logic [63:0] dat, input logic [7:0] s,
                            input int lead, input int bwait, output logic [1:0] br,
                            output int b_c);
        bit aw_ok = 0, w_ok = 0, ok = 0;
        int n = 0, bseen = 0;
        br = 0; b_c = 0;
        ls_wvalid = 1; ls_wdata = dat; ls_wstrb = s; ls_awaddr = a; ls_awvalid = (lead == 0);
        while (!(aw_ok && w_ok) && n < 300) begin
            @(negedge clk);
            if (ls_awvalid && ls_awready) aw_ok = 1;
            if (ls_wvalid && ls_wready) w_ok = 1;
            @(posedge clk);
            #1;
            n++;
            if (!aw_ok && n >= lead) ls_awvalid = 1;
        end
        if (!(aw_ok && w_ok)) chk("ls_write_aw_w_timeout", 0, 1);
        ls_awvalid = 0; ls_wvalid = 0;
        for (int k = 0; k < 300 && !ok; k++) begin
            @(negedge clk);
            if (ls_bvalid && ls_bready) begin ok = 1; br = ls_bresp; b_c = cyc; end
            if (ls_bvalid) bseen++;
            @(posedge clk);
            #1;
            if (bseen >= bwait) ls_bready = 1;
        end
        if (!ok) chk("ls_write_b_timeout", 0, 1);
        ls_bready = 0;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #2 rst_n = 0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    // ---------------- directed sequence
    initial begin
        logic [63:0] d0, d1, d2, d3;
        logic [1:0]  r0, r1, r2, r3, rb;
        int          q0, c0, q1, c1, bc;

        #1 rst_n = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_grant", grant, 2'b00);
        chk("reset_valids", {m_arvalid, m_awvalid, m_wvalid, m_rready, m_bready}, 0);
        @(posedge clk);
        #1 rst_n = 1;
        @(posedge clk);
        #1;

        // IFU-only read
        rd_lat = 2; rdata_cfg = 64'h0000_0000_0010_0073; gq.delete();
        if_read(64'h8000_0000, d0, r0, q0, c0);
        chk("t1_grant_req_cycle", grant_at[q0 % 4096], 2'b00);
        chk("t1_grant_next", grant_at[(q0 + 1) % 4096], 2'b01);
        chk("t1_rdata", d0, 64'h0000_0000_0010_0073);
        chk("t1_rresp", r0, 2'b00);
        chk("t1_slave_araddr", s_araddr, 64'h8000_0000);
        chk("t1_idle_after_r", grant_at[(c0 + 1) % 4096], 2'b00);

        // Simultaneous IFU and LSU read straight after reset
        do_reset();
        gq.delete(); rdata_cfg = 64'h0000_0000_0000_1234;
        fork
            if_read(64'h8000_0010, d0, r0, q0, c0);
            ls_read(64'h8000_0020, d1, r1);
        join
        chk("t2_first_owner", gq[0], 1);
        chk("t2_second_owner", gq[1], 2);
        chk("t2_bubble", grant_at[(c0 + 1) % 4096], 2'b00);
        chk("t2_ls_grant", grant_at[(c0 + 2) % 4096], 2'b10);
        chk("t2_ls_rdata", d1, 64'h0000_0000_0000_1234);

        // Continuous contention, 4 + 4 reads
        gq.delete(); rd_lat = 1;
        fork
            repeat (4) if_read(64'h8000_0100, d2, r2, q1, c1);
            repeat (4) ls_read(64'h8000_0200, d3, r3);
        join
        chk("t3_count", gq.size(), 8);
        for (int i = 0; i < 8; i++) chk($sformatf("t3_alt%0d", i), gq[i], (i % 2 == 0) ? 1 : 2);

        // LSU write, W two cycles ahead of AW, bready delayed
        gq.delete();
        ls_write(64'h8000_1000, 64'h0000_0000_DEAD_BEEF, 8'h0F, 2, 2, rb, bc);
        chk("t4_owner", gq[0], 3);
        chk("t4_count", gq.size(), 1);
        chk("t4_awaddr", s_awaddr, 64'h8000_1000);
        chk("t4_wdata", s_wdata, 64'h0000_0000_DEAD_BEEF);
        chk("t4_wstrb", s_wstrb, 8'h0F);
        chk("t4_aw_after_w", s_aw_cyc - s_w_cyc, 1);
        chk("t4_bresp", rb, 2'b00);
        chk("t4_held_on_b", grant_at[bc % 4096], 2'b11);
        chk("t4_idle_after_b", grant_at[(bc + 1) % 4096], 2'b00);

        // LSU read and write pending together: write first; error bresp forwarded
        gq.delete(); bresp_cfg = 2'b11; rdata_cfg = 64'hCAFE_0000_0000_0001;
        fork
            ls_write(64'h8000_1008, 64'h1122_3344_5566_7788, 8'hFF, 0, 0, rb, bc);
            ls_read(64'h8000_2000, d1, r1);
        join
        bresp_cfg = 2'b00;
        chk("t5_write_first", gq[0], 3);
        chk("t5_read_second", gq[1], 2);
        chk("t5_bresp_decerr", rb, 2'b11);
        chk("t5_rdata", d1, 64'hCAFE_0000_0000_0001);

        // SLVERR to IFU, then contention follows normal round-robin
        rresp_cfg = 2'b10; rdata_cfg = 64'h0000_0000_0BAD_0001;
        if_read(64'h8000_0004, d0, r0, q0, c0);
        chk("t6_rresp_slverr", r0, 2'b10);
        chk("t6_rdata", d0, 64'h0000_0000_0BAD_0001);
        rresp_cfg = 2'b00; gq.delete();
        fork
            if_read(64'h8000_0008, d0, r0, q0, c0);
            ls_read(64'h8000_0030, d1, r1);
        join
        chk("t6_lsu_first", gq[0], 2);
        chk("t6_ifu_second", gq[1], 1);
        chk("t6_rresp_okay", r0, 2'b00);

        // Reset during an LS_RD whose address is still stalled
        ar_ready_en = 0; ls_araddr = 64'h8000_3000; ls_arvalid = 1;
        begin
            bit seen = 0;
            for (int n = 0; n < 20 && !seen; n++) begin
                @(negedge clk);
                if (grant == 2'b10) seen = 1;
            end
            chk("t7_granted", grant, 2'b10);
            chk("t7_arvalid_up", m_arvalid, 1'b1);
        end
        @(posedge clk);
        #2 rst_n = 0;
        #1;
        chk("t7_reset_grant", grant, 2'b00);
        chk("t7_reset_valids", {m_arvalid, m_awvalid, m_wvalid, ls_arready, ls_rvalid}, 0);
        ls_arvalid = 0; ar_ready_en = 1;
        repeat (2) @(posedge clk);
        #1 rst_n = 1;
        @(posedge clk);
        #1;

        // Recovery: a plain IFU read after the reset
        gq.delete(); rdata_cfg = 64'h0000_0000_0000_0013; rd_lat = 2;
        if_read(64'h8000_0040, d0, r0, q0, c0);
        chk("t8_owner", gq[0], 1);
        chk("t8_count", gq.size(), 1);
        chk("t8_rdata", d0, 64'h0000_0000_0000_0013);
        chk("t8_latency", grant_at[(q0 + 1) % 4096], 2'b01);

        repeat (2) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/ysyx_22050019_axi_arb.md
# ysyx_22050019_axi_arb

Two-master, one-slave AXI-lite arbiter that shares the single memory/SRAM AXI-lite port between the instruction-fetch unit (read-only master) and the load/store unit (read/write master). It sits between the IFU/LSU AXI master ports and the memory slave. It grants one whole transaction at a time, with round-robin fairness between the two masters, and forwards handshakes unmodified.

## Interface
- ADDR_W, 64, address width of all AR/AW channels
- DATA_W, 64, data width of all R/W channels; strobe width is DATA_W/8
- clk  in  1  single clock, all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- if_arvalid / if_araddr  in  1 / ADDR_W  IFU read-address request
- if_arready  out  1  IFU read-address accept
- if_rvalid / if_rdata / if_rresp  out  1 / DATA_W / 2  IFU read response
- if_rready  in  1  IFU read-response accept
- ls_arvalid / ls_araddr  in  1 / ADDR_W  LSU read-address request; ls_arready out 1
- ls_rvalid / ls_rdata / ls_rresp  out  1 / DATA_W / 2  LSU read response; ls_rready in 1
- ls_awvalid / ls_awaddr  in  1 / ADDR_W  LSU write address; ls_awready out 1
- ls_wvalid / ls_wdata / ls_wstrb  in  1 / DATA_W / DATA_W/8  LSU write data; ls_wready out 1
- ls_bvalid / ls_bresp  out  1 / 2  LSU write response; ls_bready in 1
- m_arvalid / m_araddr  out  1 / ADDR_W  to slave; m_arready in 1
- m_rvalid / m_rdata / m_rresp  in  1 / DATA_W / 2  from slave; m_rready out 1
- m_awvalid / m_awaddr  out  1 / ADDR_W; m_awready in 1
- m_wvalid / m_wdata / m_wstrb  out  1 / DATA_W / DATA_W/8; m_wready in 1
- m_bvalid / m_bresp  in  1 / 2; m_bready out 1
- grant  out  2  current owner: 00 none, 01 IFU read, 10 LSU read, 11 LSU write

## Operation
- States: IDLE, IF_RD, LS_RD, LS_WR. grant encodes the state directly (IDLE=00, IF_RD=01, LS_RD=10, LS_WR=11).
- Requests are pending as follows: IF = if_arvalid; LS_WR = ls_awvalid | ls_wvalid; LS_RD = ls_arvalid.
- In IDLE, all m_* valids/readies and all master-side readies/valids are 0. Nothing is combinationally forwarded.
- IDLE arbitration:
  - Only one master pending: grant it.
  - Both pending: grant the master not in last_owner.
  - LSU granted with both read and write pending: LS_WR wins.
- last_owner is a 1-bit register, 0=IFU and 1=LSU. It updates on entry to a granted state.
- IF_RD / LS_RD:
  - The owner's AR and R channels are wired straight through to m_AR and m_R.
  - The non-owner sees arready=0 and rvalid=0.
  - All write channels are held at 0.
  - A single ar_done flag masks m_arvalid after the AR handshake.
- LS_WR:
  - ls_AW, ls_W and m_B are wired through.
  - aw_done and w_done flags mask m_awvalid and m_wvalid after their respective handshakes.
  - AW and W may complete in either order or in the same cycle.
- Completion:
  - Reads complete on the cycle with m_rvalid & m_rready.
  - Writes complete on m_bvalid & m_bready.
  - The FSM returns to IDLE on that edge and the done flags clear.
- rresp and bresp pass through unchanged, including SLVERR/DECERR. Error responses do not alter arbitration.
- A request withdrawn before its AR/AW handshake is an AXI protocol violation. Its behaviour is undefined and not checked.

## Timing
- Reset (asynchronous): state = IDLE, last_owner = 1 (IFU wins the first contended grant), done flags = 0, grant = 00. All outputs are 0 while rst_n is low.
- Arbitration latency:
  - Request first visible in IDLE at cycle N; the grant registers at edge N+1.
  - m_arvalid / m_awvalid assert in cycle N+1.
- Turnaround: one IDLE bubble cycle after every completion. Back-to-back transactions are therefore spaced by ≥1 cycle.
- Pass-through paths (ready/valid/data) are combinational while granted. The arbiter adds no registers on the data path.
- Reset asserted mid-transaction: the FSM returns to IDLE immediately. In-flight slave handshakes are abandoned, and the slave is reset by the same rst_n.
- No outstanding-transaction depth beyond 1. A new request is never forwarded before the current R/B completes.

## Test plan
- IFU-only read:
  - Stimulus: if_araddr=0x8000_0000, slave returns rdata=0x0000_0000_0010_0073 after 2 cycles.
  - Required response: grant=01 one cycle after request, if_rdata matches, grant=00 the cycle after the R handshake.
- Simultaneous IF and LSU read right after reset:
  - Stimulus: both masters request in the same cycle.
  - Required response: IFU is served first (grant=01), then LSU (grant=10) after one IDLE cycle. ls_arready stays 0 throughout the IFU transaction.
- Continuous contention for 8 transactions:
  - Required response: grants strictly alternate 01/10. Neither master waits more than one transaction.
- LSU write with W before AW:
  - Stimulus: W presented 2 cycles before AW, wstrb=0x0F, wdata=0xDEAD_BEEF.
  - Required response: m_wvalid drops after its handshake, AW completes later, m_bready follows ls_bready, and the FSM leaves LS_WR only on the B handshake.
- LSU read+write pending together with IFU idle:
  - Required response: LS_WR is granted before LS_RD.
- Slave SLVERR and async reset mid-read:
  - Stimulus: slave returns rresp=2'b10 to the IFU; then rst_n is pulsed low during an LS_RD before R.
  - Required response: if_rresp=2'b10 and the next grant is unaffected. On reset, grant=00 and all m_* valids drop to 0 the same cycle.
